// File: rtl/madnes_vram_pkg.sv
// Shared sprite VRAM definitions: field widths, the 128-bit sprite line
// type, the fetcher state encoding and a pixel-extraction helper.
package madnes_vram_pkg;

    localparam int SPRITE_ID_W  = 8;
    localparam int SPRITE_ROW_W = 4;
    localparam int PIX_W        = 8;
    localparam int LINE_PIXELS  = 16;

    typedef logic [LINE_PIXELS*PIX_W-1:0] sprite_line_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } fetch_state_t;

    // Pixel n of a line sits in byte n: even pixels in the low byte of each
    // 16-bit pair, odd pixels in the high byte.
    function automatic logic [PIX_W-1:0] line_pixel(input sprite_line_t line,
                                                     input logic [3:0]   idx);
        return line[idx*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/sprite_line_shifter.sv
// Line buffer plus 16-entry pixel serializer with ready/valid output.
// A load replaces the buffer and restarts at pixel 0 (or 15 when flipped).
module sprite_line_shifter
    import madnes_vram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  sprite_line_t     line,
    input  logic             hflip,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_last,
    output logic             line_done
);

    localparam logic [3:0] LAST_IDX = 4'(LINE_PIXELS - 1);

    sprite_line_t line_q;
    logic         hflip_q;
    logic         valid_q;
    logic [3:0]   idx;
    logic [3:0]   pos;

    // Buffer load and one-pixel advance per output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            hflip_q <= 1'b0;
            valid_q <= 1'b0;
            idx     <= '0;
        end else if (load) begin
            line_q  <= line;
            hflip_q <= hflip;
            valid_q <= 1'b1;
            idx     <= '0;
        end else if (valid_q && pix_ready) begin
            if (idx == LAST_IDX) begin
                valid_q <= 1'b0;
            end
            idx <= idx + 4'd1;
        end
    end

    assign pos       = hflip_q ? (LAST_IDX - idx) : idx;
    assign pix_valid = valid_q;
    assign pix_data  = valid_q ? line_pixel(line_q, pos) : '0;
    assign pix_last  = valid_q && (idx == LAST_IDX);
    assign line_done = valid_q && pix_ready && (idx == LAST_IDX);

endmodule

// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: accepts a (sprite, row, flip) request, reads one
// 128-bit line from sprite VRAM and streams it out as 16 pixels.
// Optional macro SPRITE_FETCH_PREFETCH_EN adds a spare line buffer so the
// next request can be fetched while the current line is still shifting.
//
// state    | meaning
// ST_IDLE  | no line in flight, request port open
// ST_WAIT  | address issued, counting down the VRAM read latency
// ST_SHIFT | line loaded, pixels streaming to the consumer
module sprite_line_fetcher
    import madnes_vram_pkg::*;
#(
    parameter int READ_LATENCY = 1
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [SPRITE_ID_W-1:0]              req_sprite,
    input  logic [SPRITE_ROW_W-1:0]             req_row,
    input  logic                                req_hflip,
    input  logic                                req_vflip,
    output logic [SPRITE_ID_W+SPRITE_ROW_W-1:0] vram_read_addr,
    input  sprite_line_t                        vram_read_data,
    output logic                                pix_valid,
    input  logic                                pix_ready,
    output logic [PIX_W-1:0]                    pix_data,
    output logic                                pix_last
);

    localparam logic [1:0]              LAT_LOAD = 2'(READ_LATENCY - 1);
    localparam logic [SPRITE_ROW_W-1:0] ROW_MAX  = '1;

    fetch_state_t state, state_nxt;
    logic         run_en;
    logic         fetch_busy;
    logic [1:0]   lat_cnt;
    logic         fetch_hflip;
    logic         accept;
    logic         fetch_done;
    logic         line_done;
    logic         ld_shift;
    logic         ld_hflip;
    sprite_line_t ld_line;

    assign accept     = req_valid && req_ready;
    assign fetch_done = fetch_busy && (lat_cnt == 2'd0);

`ifdef SPRITE_FETCH_PREFETCH_EN
    logic         spare_full;
    logic         spare_hflip;
    logic         spare_set;
    sprite_line_t spare_line;

    // Only one fetch may be in flight, and only into an empty spare buffer
    assign req_ready = run_en && ((state == ST_IDLE) ||
                                  ((state == ST_SHIFT) && !spare_full && !fetch_busy));
`else
    assign req_ready = run_en && (state == ST_IDLE);
`endif

    // Next-state decode and shifter load selection
    always_comb begin
        state_nxt = state;
        ld_shift  = 1'b0;
        ld_line   = vram_read_data;
        ld_hflip  = fetch_hflip;
`ifdef SPRITE_FETCH_PREFETCH_EN
        spare_set = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch_done) begin
                    ld_shift  = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
`ifdef SPRITE_FETCH_PREFETCH_EN
                // Chain the next line into the shifter on the last handshake
                if (line_done) begin
                    if (spare_full) begin
                        ld_shift = 1'b1;
                        ld_line  = spare_line;
                        ld_hflip = spare_hflip;
                    end else if (fetch_done) begin
                        ld_shift = 1'b1;
                    end else if (fetch_busy || accept) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (fetch_done) begin
                    spare_set = 1'b1;
                end
`else
                if (line_done) state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, request capture and read-latency down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            run_en         <= 1'b0;
            fetch_busy     <= 1'b0;
            lat_cnt        <= '0;
            fetch_hflip    <= 1'b0;
            vram_read_addr <= '0;
        end else begin
            state  <= state_nxt;
            run_en <= 1'b1;
            if (accept) begin
                vram_read_addr <= {req_sprite, req_vflip ? (ROW_MAX - req_row) : req_row};
                fetch_hflip    <= req_hflip;
                fetch_busy     <= 1'b1;
                lat_cnt        <= LAT_LOAD;
            end else if (fetch_busy) begin
                if (lat_cnt == 2'd0) begin
                    fetch_busy <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
            end
        end
    end

`ifdef SPRITE_FETCH_PREFETCH_EN
    // Spare line holds a prefetched read until the current line drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spare_full  <= 1'b0;
            spare_hflip <= 1'b0;
            spare_line  <= '0;
        end else if (spare_set) begin
            spare_full  <= 1'b1;
            spare_hflip <= fetch_hflip;
            spare_line  <= vram_read_data;
        end else if (ld_shift && spare_full) begin
            spare_full <= 1'b0;
        end
    end
`endif

    sprite_line_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld_shift),
        .line      (ld_line),
        .hflip     (ld_hflip),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .line_done (line_done)
    );

endmodule
